// File: rtl/mmio_test_responder.sv
// MMIO test device: TOHOST exit capture, console byte FIFO, cycle counter, status.
// Define MMIO_WATCHDOG_EN to build the optional exit watchdog.
module mmio_test_responder #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_1000),
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              halt,
  output logic              pass,
  output logic [30:0]       exit_code
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic accept;
  logic hit;
  logic [1:0] sel;
  logic push;
  logic pop;
  logic tohost_ok;
  logic fifo_full;
  logic fifo_empty;
  logic wd_hit;
  logic wd_fired;
  logic [31:0] status;
  logic unused_addr_bits;

  logic halt_q, halt_d;
  logic pass_q, pass_d;
  logic [30:0] exit_q, exit_d;
  logic [31:0] cycle_q, cycle_d;
  logic rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0] mem_q [FIFO_DEPTH];

  assign fifo_full = count_q == CNT_W'(FIFO_DEPTH);
  assign fifo_empty = count_q == '0;
  assign req_ready = !fifo_full;
  assign accept = req_valid && req_ready;
  assign hit = req_addr[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4];
  assign sel = req_addr[3:2];
  assign unused_addr_bits = ^req_addr[1:0];

  assign push = accept && hit && req_we
              && sel == 2'd1 && req_wstrb[0];
  assign pop = !fifo_empty && tx_ready;

  assign tohost_ok = accept && hit && req_we
                   && sel == 2'd0
                   && req_wstrb == 4'hF
                   && req_wdata[0] && !halt_q;

  assign status = {21'b0, wd_fired, halt_q,
                   fifo_full, 8'(count_q)};

`ifdef MMIO_WATCHDOG_EN
  logic [31:0] wd_q, wd_d;
  logic wd_fired_q, wd_fired_d;

  assign wd_hit = !halt_q && wd_q == 32'(TIMEOUT_CYC);
  assign wd_fired = wd_fired_q;

  always_comb begin
    wd_d = wd_q;
    wd_fired_d = wd_fired_q;
    if (!halt_q) wd_d = wd_q + 32'd1;
    if (wd_hit && !tohost_ok) wd_fired_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
      wd_fired_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      wd_fired_q <= wd_fired_d;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYC;
  assign wd_hit = 1'b0;
  assign wd_fired = 1'b0;
`endif

  // A valid TOHOST write wins over a watchdog expiry on the same edge.
  always_comb begin
    halt_d = halt_q;
    pass_d = pass_q;
    exit_d = exit_q;
    if (tohost_ok) begin
      halt_d = 1'b1;
      exit_d = req_wdata[31:1];
      pass_d = req_wdata[31:1] == 31'd0;
    end else if (wd_hit) begin
      halt_d = 1'b1;
      exit_d = 31'h0DEAD;
      pass_d = 1'b0;
    end
    cycle_d = halt_d ? cycle_q : cycle_q + 32'd1;
  end

  always_comb begin
    rsp_valid_d = accept;
    rsp_rdata_d = '0;
    if (accept && hit && !req_we) begin
      unique case (1'b1)
        sel == 2'd2: rsp_rdata_d = cycle_q;
        sel == 2'd3: rsp_rdata_d = status;
        default:     rsp_rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    wr_d = push ? wr_q + PTR_W'(1) : wr_q;
    rd_d = pop ? rd_q + PTR_W'(1) : rd_q;
    count_d = count_q;
    if (push && !pop) count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_q <= 1'b0;
      pass_q <= 1'b0;
      exit_q <= '0;
      cycle_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      halt_q <= halt_d;
      pass_q <= pass_d;
      exit_q <= exit_d;
      cycle_q <= cycle_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= req_wdata[7:0];
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign tx_valid = !fifo_empty;
  assign tx_data = fifo_empty ? 8'h00 : mem_q[rd_q];
  assign halt = halt_q;
  assign pass = pass_q;
  assign exit_code = exit_q;

endmodule

// File: tb/tb_mmio_test_responder.sv
// Scoreboard bench for mmio_test_responder: responses and console bytes
// are queued when driven and checked when the device produces them.
module tb_mmio_test_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0] req_wstrb = '0;
  logic rsp_valid;
  logic [31:0] rsp_rdata;
  logic tx_valid;
  logic [7:0] tx_data;
  logic tx_ready = 1'b0;
  logic halt;
  logic pass;
  logic [30:0] exit_code;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic chk;
    logic [31:0] d;
  } rsp_t;

  rsp_t rsp_q[$];
  logic [7:0] byte_q[$];
  rsp_t exp_r;
  logic [7:0] exp_b;

  always #5 clk = ~clk;

  mmio_test_responder #(
    .ADDR_W(32),
    .BASE_ADDR(BASE),
    .FIFO_DEPTH(8),
    .TIMEOUT_CYC(100000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .halt(halt),
    .pass(pass),
    .exit_code(exit_code)
  );

  // Inputs change just after posedge, so negedge sees what the next edge uses.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (rsp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rsp_orphan: got rsp rdata=%h, required no response", rsp_rdata);
      end else begin
        exp_r = rsp_q.pop_front();
        if (exp_r.chk) begin
          vectors++;
          if (rsp_rdata !== exp_r.d) begin
            miscompares++;
            $display("FAIL rsp_rdata: got %h, required %h", rsp_rdata, exp_r.d);
          end
        end
      end
    end
    if (!rst && tx_valid && tx_ready) begin
      vectors++;
      if (byte_q.size() == 0) begin
        miscompares++;
        $display("FAIL tx_orphan: got byte %h, required none", tx_data);
      end else begin
        exp_b = byte_q.pop_front();
        if (tx_data !== exp_b) begin
          miscompares++;
          $display("FAIL tx_data: got %h, required %h", tx_data, exp_b);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] st,
                       input logic chk, input logic [31:0] exp,
                       output logic [31:0] got);
    int n;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_we = we;
    req_addr = addr;
    req_wdata = wd;
    req_wstrb = st;
    n = 0;
    while (!req_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL issue_ready: req_ready=0 after %0d cycles, required 1", n);
      req_valid = 1'b0;
      got = '0;
    end else begin
      rsp_q.push_back(rsp_t'({chk, exp}));
      if (we && addr == BASE + 32'h4 && st[0])
        byte_q.push_back(wd[7:0]);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL rsp_latency: rsp_valid=%b one cycle after accept, required 1", rsp_valid);
      end
      got = rsp_rdata;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    rsp_q.delete();
    byte_q.delete();
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_rdata, tx_valid, tx_data, halt, pass, exit_code}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0, 1'b0, 31'h0}) begin
      miscompares++;
      $display("FAIL reset_values: rdy=%b rv=%b rd=%h txv=%b txd=%h h=%b p=%b ec=%h, required 1 0 0 0 0 0 0 0",
               req_ready, rsp_valid, rsp_rdata, tx_valid, tx_data, halt, pass, exit_code);
    end
    do_reset();
  endtask

  task automatic test_status_cycle();
    logic [31:0] got, c1, c2;
    issue(1'b0, BASE + 32'hC, 32'h0, 4'h0, 1'b1, 32'h0, got);
    issue(1'b0, BASE + 32'h8, 32'h0, 4'h0, 1'b0, 32'h0, c1);
    repeat (3) @(posedge clk);
    issue(1'b0, BASE + 32'h8, 32'h0, 4'h0, 1'b0, 32'h0, c2);
    vectors++;
    if (c2 - c1 !== 32'd5) begin
      miscompares++;
      $display("FAIL cycle_delta: got %0d, required 5", c2 - c1);
    end
  endtask

  task automatic test_tohost_pass();
    logic [31:0] got, c1, c2;
    do_reset();
    issue(1'b1, BASE, 32'h1, 4'hF, 1'b1, 32'h0, got);
    vectors++;
    if ({halt, pass, exit_code} !== {1'b1, 1'b1, 31'h0}) begin
      miscompares++;
      $display("FAIL tohost_pass: h=%b p=%b ec=%h, required 1 1 0", halt, pass, exit_code);
    end
    issue(1'b1, BASE, 32'h7, 4'hF, 1'b1, 32'h0, got);
    vectors++;
    if ({halt, pass, exit_code} !== {1'b1, 1'b1, 31'h0}) begin
      miscompares++;
      $display("FAIL tohost_first_wins: h=%b p=%b ec=%h, required 1 1 0", halt, pass, exit_code);
    end
    issue(1'b0, BASE + 32'h8, 32'h0, 4'h0, 1'b0, 32'h0, c1);
    repeat (3) @(posedge clk);
    issue(1'b0, BASE + 32'h8, 32'h0, 4'h0, 1'b0, 32'h0, c2);
    vectors++;
    if (c2 !== c1) begin
      miscompares++;
      $display("FAIL cycle_frozen: got %h then %h, required equal", c1, c2);
    end
    issue(1'b0, BASE + 32'hC, 32'h0, 4'h0, 1'b1, 32'h200, got);
  endtask

  task automatic test_tohost_fail();
    logic [31:0] got;
    do_reset();
    issue(1'b1, BASE, 32'h7, 4'h3, 1'b1, 32'h0, got);
    issue(1'b1, BASE, 32'h6, 4'hF, 1'b1, 32'h0, got);
    vectors++;
    if (halt !== 1'b0) begin
      miscompares++;
      $display("FAIL tohost_ignored: halt=%b, required 0", halt);
    end
    issue(1'b1, BASE, 32'h7, 4'hF, 1'b1, 32'h0, got);
    vectors++;
    if ({halt, pass, exit_code} !== {1'b1, 1'b0, 31'd3}) begin
      miscompares++;
      $display("FAIL tohost_fail: h=%b p=%b ec=%h, required 1 0 3", halt, pass, exit_code);
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] got;
    string msg;
    int n;
    msg = "Hiabcdef";
    do_reset();
    for (int i = 0; i < 7; i++)
      issue(1'b1, BASE + 32'h4, {24'h0, msg[i]}, 4'h1, 1'b1, 32'h0, got);
    issue(1'b0, BASE + 32'hC, 32'h0, 4'h0, 1'b1, 32'h7, got);
    issue(1'b1, BASE + 32'h4, {24'h0, msg[7]}, 4'h1, 1'b1, 32'h0, got);
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_ready: req_ready=%b, required 0", req_ready);
    end
    vectors++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h48}) begin
      miscompares++;
      $display("FAIL full_head: txv=%b txd=%h, required 1 48", tx_valid, tx_data);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_stall: req_ready=%b, required 0", req_ready);
    end
    @(posedge clk);
    #1 tx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_pop: req_ready=%b, required 1", req_ready);
    end
    n = 0;
    while (tx_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (tx_valid !== 1'b0 || byte_q.size() != 0) begin
      miscompares++;
      $display("FAIL full_drain: txv=%b left=%0d, required 0 0", tx_valid, byte_q.size());
    end
    issue(1'b0, BASE + 32'hC, 32'h0, 4'h0, 1'b1, 32'h0, got);
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      req_we = 1'b1;
      req_addr = BASE + 32'h4;
      req_wdata = 32'h30 + 32'(i);
      req_wstrb = 4'h1;
      vectors++;
      if (req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready: req_ready=%b at write %0d, required 1", req_ready, i);
      end
      if (i > 0) begin
        vectors++;
        if (tx_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_txv: tx_valid=%b at write %0d, required 1", tx_valid, i);
        end
      end
      rsp_q.push_back(rsp_t'({1'b1, 32'h0}));
      byte_q.push_back(8'h30 + 8'(i));
      @(posedge clk);
      #1;
    end
    req_we = 1'b0;
    req_addr = BASE + 32'hC;
    rsp_q.push_back(rsp_t'({1'b1, 32'h1}));
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while ((tx_valid || rsp_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    vectors++;
    if (byte_q.size() != 0 || rsp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_drain: bytes left=%0d rsps left=%0d, required 0 0",
               byte_q.size(), rsp_q.size());
    end
  endtask

  task automatic test_miss();
    logic [31:0] got;
    do_reset();
    issue(1'b0, BASE + 32'h10, 32'h0, 4'h0, 1'b1, 32'h0, got);
    issue(1'b1, BASE + 32'h10, 32'h1, 4'hF, 1'b1, 32'h0, got);
    issue(1'b1, BASE + 32'h14, 32'h5A, 4'h1, 1'b1, 32'h0, got);
    issue(1'b0, BASE, 32'h0, 4'h0, 1'b1, 32'h0, got);
    issue(1'b0, BASE + 32'h4, 32'h0, 4'h0, 1'b1, 32'h0, got);
    issue(1'b1, BASE + 32'h8, 32'h1, 4'hF, 1'b1, 32'h0, got);
    vectors++;
    if ({halt, tx_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL miss_no_effect: halt=%b txv=%b, required 0 0", halt, tx_valid);
    end
    issue(1'b0, BASE + 32'hC, 32'h0, 4'h0, 1'b1, 32'h0, got);
  endtask

  task automatic test_async_reset();
    logic [31:0] got;
    do_reset();
    issue(1'b1, BASE, 32'h3, 4'hF, 1'b1, 32'h0, got);
    issue(1'b1, BASE + 32'h4, 32'h41, 4'h1, 1'b1, 32'h0, got);
    vectors++;
    if ({halt, pass, exit_code, tx_valid} !== {1'b1, 1'b0, 31'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL pre_reset: h=%b p=%b ec=%h txv=%b, required 1 0 1 1",
               halt, pass, exit_code, tx_valid);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = BASE + 32'h4;
    req_wdata = 32'h42;
    req_wstrb = 4'h1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_rdata, tx_valid, tx_data, halt, pass, exit_code}
        !== {1'b1, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0, 1'b0, 31'h0}) begin
      miscompares++;
      $display("FAIL async_reset: rdy=%b rv=%b rd=%h txv=%b txd=%h h=%b p=%b ec=%h, required 1 0 0 0 0 0 0 0",
               req_ready, rsp_valid, rsp_rdata, tx_valid, tx_data, halt, pass, exit_code);
    end
    req_valid = 1'b0;
    rsp_q.delete();
    byte_q.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({rsp_valid, tx_valid, halt} !== 3'b000) begin
      miscompares++;
      $display("FAIL post_reset: rv=%b txv=%b h=%b, required 0 0 0", rsp_valid, tx_valid, halt);
    end
    issue(1'b0, BASE + 32'hC, 32'h0, 4'h0, 1'b1, 32'h0, got);
  endtask

  initial begin
    test_reset();
    test_status_cycle();
    test_tohost_pass();
    test_tohost_fail();
    test_fifo_full();
    test_back_to_back();
    test_miss();
    test_async_reset();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: run still active at %0t, required finished", $time);
    $fatal(1, "time limit");
  end

endmodule
